stage_is_multi: RTL and testbench

Parametrised N-lane issue stage between the reservation station and execute. Per lane it:
- reads both source operands from the PRF, with same-cycle CDB bypass;
- registers the operand values plus an opaque decoded payload into an IS/EX pipeline register;
- supports per-lane valid/ready backpressure from EX and a global flush.

---
 rtl/stage_is_multi.sv | 130 +++++++++++++
 tb/tb_stage_is_multi.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/stage_is_multi.sv
// N-lane issue stage: PRF operand read with tag-0 zeroing, IS/EX pipeline register, per-lane stall counters.
// Optional same-cycle CDB operand bypass is enabled by defining IS_CDB_FWD_EN.
module stage_is_multi #(
    parameter int ISSUE_WIDTH = 2,
    parameter int CDB_WIDTH   = 2,
    parameter int PRF_IDX_W   = 6,
    parameter int XLEN        = 32,
    parameter int ROB_IDX_W   = 5,
    parameter int PAYLOAD_W   = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [ISSUE_WIDTH-1:0]              rs_valid,
    input  logic [ISSUE_WIDTH*PRF_IDX_W-1:0]    rs_t1,
    input  logic [ISSUE_WIDTH*PRF_IDX_W-1:0]    rs_t2,
    input  logic [ISSUE_WIDTH*PRF_IDX_W-1:0]    rs_dest,
    input  logic [ISSUE_WIDTH*ROB_IDX_W-1:0]    rs_rob_idx,
    input  logic [ISSUE_WIDTH*PAYLOAD_W-1:0]    rs_payload,
    output logic [ISSUE_WIDTH-1:0]              is_ready,
    output logic [2*ISSUE_WIDTH*PRF_IDX_W-1:0]  prf_rd_tag,
    input  logic [2*ISSUE_WIDTH*XLEN-1:0]       prf_rd_data,
    input  logic [CDB_WIDTH-1:0]                cdb_valid,
    input  logic [CDB_WIDTH*PRF_IDX_W-1:0]      cdb_tag,
    input  logic [CDB_WIDTH*XLEN-1:0]           cdb_data,
    input  logic [ISSUE_WIDTH-1:0]              ex_ready,
    output logic [ISSUE_WIDTH-1:0]              ex_valid,
    output logic [ISSUE_WIDTH*XLEN-1:0]         ex_rs1_value,
    output logic [ISSUE_WIDTH*XLEN-1:0]         ex_rs2_value,
    output logic [ISSUE_WIDTH*PRF_IDX_W-1:0]    ex_dest,
    output logic [ISSUE_WIDTH*ROB_IDX_W-1:0]    ex_rob_idx,
    output logic [ISSUE_WIDTH*PAYLOAD_W-1:0]    ex_payload,
    output logic [ISSUE_WIDTH*STALL_CNT_W-1:0]  stall_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    lane_state_t             lane_state [ISSUE_WIDTH];
    logic [XLEN-1:0]         opnd_val   [2*ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0]  load;

    // Read port 2i carries t1 of lane i, port 2i+1 carries t2.
    always_comb begin
        prf_rd_tag = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            prf_rd_tag[(2*i)*PRF_IDX_W   +: PRF_IDX_W] = rs_t1[i*PRF_IDX_W +: PRF_IDX_W];
            prf_rd_tag[(2*i+1)*PRF_IDX_W +: PRF_IDX_W] = rs_t2[i*PRF_IDX_W +: PRF_IDX_W];
        end
    end

`ifdef IS_CDB_FWD_EN
    always_comb begin
        logic hit;
        for (int unsigned p = 0; p < 2*ISSUE_WIDTH; p++) begin
            opnd_val[p] = prf_rd_data[p*XLEN +: XLEN];
            hit = 1'b0;
            // Ascending scan with a hit flag: the lowest-index matching port wins.
            for (int unsigned c = 0; c < CDB_WIDTH; c++) begin
                if (!hit && cdb_valid[c] &&
                    cdb_tag[c*PRF_IDX_W +: PRF_IDX_W] == prf_rd_tag[p*PRF_IDX_W +: PRF_IDX_W]) begin
                    opnd_val[p] = cdb_data[c*XLEN +: XLEN];
                    hit = 1'b1;
                end
            end
            if (prf_rd_tag[p*PRF_IDX_W +: PRF_IDX_W] == '0)
                opnd_val[p] = '0;
        end
    end
`else
    logic unused_cdb;
    assign unused_cdb = ^{cdb_valid, cdb_tag, cdb_data};

    always_comb begin
        for (int unsigned p = 0; p < 2*ISSUE_WIDTH; p++) begin
            opnd_val[p] = prf_rd_data[p*XLEN +: XLEN];
            if (prf_rd_tag[p*PRF_IDX_W +: PRF_IDX_W] == '0)
                opnd_val[p] = '0;
        end
    end
`endif

    always_comb begin
        ex_valid = '0;
        is_ready = '0;
        load     = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            ex_valid[i] = (lane_state[i] == FULL);
            is_ready[i] = (lane_state[i] == EMPTY) || ex_ready[i];
            load[i]     = rs_valid[i] && is_ready[i] && !flush;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < ISSUE_WIDTH; i++)
                lane_state[i] <= EMPTY;
            ex_rs1_value <= '0;
            ex_rs2_value <= '0;
            ex_dest      <= '0;
            ex_rob_idx   <= '0;
            ex_payload   <= '0;
            stall_cnt    <= '0;
        end else begin
            for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                if (lane_state[i] == FULL && !ex_ready[i] &&
                    stall_cnt[i*STALL_CNT_W +: STALL_CNT_W] != '1)
                    stall_cnt[i*STALL_CNT_W +: STALL_CNT_W] <=
                        stall_cnt[i*STALL_CNT_W +: STALL_CNT_W] + 1'b1;

                if (flush) begin
                    lane_state[i] <= EMPTY;
                end else if (load[i]) begin
                    lane_state[i]                          <= FULL;
                    ex_rs1_value[i*XLEN +: XLEN]           <= opnd_val[2*i];
                    ex_rs2_value[i*XLEN +: XLEN]           <= opnd_val[2*i+1];
                    ex_dest[i*PRF_IDX_W +: PRF_IDX_W]      <= rs_dest[i*PRF_IDX_W +: PRF_IDX_W];
                    ex_rob_idx[i*ROB_IDX_W +: ROB_IDX_W]   <= rs_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                    ex_payload[i*PAYLOAD_W +: PAYLOAD_W]   <= rs_payload[i*PAYLOAD_W +: PAYLOAD_W];
                end else if (ex_ready[i]) begin
                    lane_state[i] <= EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_stage_is_multi.sv
// Directed self-checking bench for stage_is_multi (default parameters).
// Operand bypass expectations follow IS_CDB_FWD_EN as seen by this compile.
module tb_stage_is_multi;

    logic          clock = 1'b0;
    logic          reset, flush;
    logic [1:0]    rs_valid;
    logic [11:0]   rs_t1, rs_t2, rs_dest;
    logic [9:0]    rs_rob_idx;
    logic [127:0]  rs_payload;
    logic [1:0]    is_ready;
    logic [23:0]   prf_rd_tag;
    logic [127:0]  prf_rd_data;
    logic [1:0]    cdb_valid;
    logic [11:0]   cdb_tag;
    logic [63:0]   cdb_data;
    logic [1:0]    ex_ready;
    logic [1:0]    ex_valid;
    logic [63:0]   ex_rs1_value, ex_rs2_value;
    logic [11:0]   ex_dest;
    logic [9:0]    ex_rob_idx;
    logic [127:0]  ex_payload;
    logic [31:0]   stall_cnt;

    int checks   = 0;
    int failures = 0;

    stage_is_multi #(
        .ISSUE_WIDTH(2), .CDB_WIDTH(2), .PRF_IDX_W(6), .XLEN(32),
        .ROB_IDX_W(5), .PAYLOAD_W(64), .STALL_CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .rs_valid(rs_valid), .rs_t1(rs_t1), .rs_t2(rs_t2), .rs_dest(rs_dest),
        .rs_rob_idx(rs_rob_idx), .rs_payload(rs_payload), .is_ready(is_ready),
        .prf_rd_tag(prf_rd_tag), .prf_rd_data(prf_rd_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_rs1_value(ex_rs1_value), .ex_rs2_value(ex_rs2_value),
        .ex_dest(ex_dest), .ex_rob_idx(ex_rob_idx), .ex_payload(ex_payload),
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    // Stimulus must never put the same tag on two valid CDB ports.
    always @(negedge clock) begin
        assert (!(cdb_valid == 2'b11 && cdb_tag[5:0] == cdb_tag[11:6]))
            else $error("duplicate CDB tag driven by stimulus");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_lane(input int i, input logic v, input logic [5:0] t1, input logic [5:0] t2,
                            input logic [5:0] dest, input logic [4:0] rob, input logic [63:0] pl,
                            input logic [31:0] d1, input logic [31:0] d2);
        rs_valid[i]                 = v;
        rs_t1[i*6 +: 6]             = t1;
        rs_t2[i*6 +: 6]             = t2;
        rs_dest[i*6 +: 6]           = dest;
        rs_rob_idx[i*5 +: 5]        = rob;
        rs_payload[i*64 +: 64]      = pl;
        prf_rd_data[(2*i)*32 +: 32]   = d1;
        prf_rd_data[(2*i+1)*32 +: 32] = d2;
    endtask

    initial begin
        logic [31:0] exp_rs2_fwd;
`ifdef IS_CDB_FWD_EN
        exp_rs2_fwd = 32'hBEEF;
`else
        exp_rs2_fwd = 32'h1234;
`endif
        reset = 1'b1; flush = 1'b0; rs_valid = '0; rs_t1 = '0; rs_t2 = '0; rs_dest = '0;
        rs_rob_idx = '0; rs_payload = '0; prf_rd_data = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0; ex_ready = 2'b11;

        // 1: reset then idle
        step(); step();
        reset = 1'b0;
        step();
        check("reset_ex_valid", 64'(ex_valid), 64'h0);
        check("reset_stall", 64'(stall_cnt), 64'h0);
        check("reset_is_ready", 64'(is_ready), 64'h3);
        check("reset_rs1", ex_rs1_value, 64'h0);

        // 2: single issue on lane0, then drains
        set_lane(0, 1'b1, 6'd5, 6'd7, 6'd3, 5'd4, 64'hCAFE_F00D_1234_5678, 32'h11, 32'h22);
        #1;
        check("prf_tag_p0", 64'(prf_rd_tag[5:0]), 64'd5);
        check("prf_tag_p1", 64'(prf_rd_tag[11:6]), 64'd7);
        step();
        rs_valid = '0;
        check("l0_valid", 64'(ex_valid), 64'h1);
        check("l0_rs1", 64'(ex_rs1_value[31:0]), 64'h11);
        check("l0_rs2", 64'(ex_rs2_value[31:0]), 64'h22);
        check("l0_dest", 64'(ex_dest[5:0]), 64'd3);
        check("l0_rob", 64'(ex_rob_idx[4:0]), 64'd4);
        check("l0_payload", ex_payload[63:0], 64'hCAFE_F00D_1234_5678);
        step();
        check("l0_drain", 64'(ex_valid), 64'h0);

        // 3: lane1 stalls 3 cycles while lane0 streams
        set_lane(1, 1'b1, 6'd1, 6'd2, 6'd10, 6'd11, 64'hAAAA, 32'h33, 32'h44);
        step();
        ex_ready = 2'b01;
        set_lane(1, 1'b1, 6'd12, 6'd13, 6'd20, 5'd21, 64'hBBBB, 32'h55, 32'h66);
        set_lane(0, 1'b1, 6'd5, 6'd7, 6'd6, 5'd1, 64'h1, 32'hA0, 32'hA1);
        #1;
        check("stall_is_ready", 64'(is_ready), 64'h1);
        step();
        check("stall_valid", 64'(ex_valid), 64'h3);
        check("stall_l0_dest_a", 64'(ex_dest[5:0]), 64'd6);
        set_lane(0, 1'b1, 6'd5, 6'd7, 6'd7, 5'd2, 64'h2, 32'hB0, 32'hB1);
        step();
        check("stall_l0_dest_b", 64'(ex_dest[5:0]), 64'd7);
        check("stall_l0_rs1_b", 64'(ex_rs1_value[31:0]), 64'hB0);
        step();
        check("stall_cnt_l1", 64'(stall_cnt[31:16]), 64'd3);
        check("stall_cnt_l0", 64'(stall_cnt[15:0]), 64'd0);
        check("stall_l1_dest", 64'(ex_dest[11:6]), 64'd10);
        check("stall_l1_rs1", 64'(ex_rs1_value[63:32]), 64'h33);
        check("stall_l1_payload", ex_payload[127:64], 64'hAAAA);
        rs_valid = '0; ex_ready = 2'b11;
        step();
        check("release_valid", 64'(ex_valid), 64'h0);
        check("release_stall_hold", 64'(stall_cnt[31:16]), 64'd3);

        // 4 + 5: tag-0 zeroing and CDB bypass
        set_lane(0, 1'b1, 6'd0, 6'd7, 6'd8, 5'd3, 64'h3, 32'hDEAD, 32'h22);
        set_lane(1, 1'b1, 6'd3, 6'd9, 6'd9, 5'd5, 64'h4, 32'h5678, 32'h1234);
        cdb_valid = 2'b11;
        cdb_tag   = {6'd9, 6'd0};
        cdb_data  = {32'hBEEF, 32'h0777};
        step();
        rs_valid = '0; cdb_valid = '0;
        check("tag0_rs1", 64'(ex_rs1_value[31:0]), 64'h0);
        check("tag0_rs2", 64'(ex_rs2_value[31:0]), 64'h22);
        check("fwd_rs1", 64'(ex_rs1_value[63:32]), 64'h5678);
        check("fwd_rs2", 64'(ex_rs2_value[63:32]), 64'(exp_rs2_fwd));
        step();

        // 6: flush while both lanes stalled
        ex_ready = 2'b00;
        set_lane(0, 1'b1, 6'd5, 6'd7, 6'd1, 5'd1, 64'h5, 32'h1, 32'h2);
        set_lane(1, 1'b1, 6'd5, 6'd7, 6'd2, 5'd2, 64'h6, 32'h3, 32'h4);
        step();
        rs_valid = '0;
        step();
        flush = 1'b1;
        set_lane(0, 1'b1, 6'd5, 6'd7, 6'd30, 5'd1, 64'h7, 32'h9, 32'h9);
        set_lane(1, 1'b1, 6'd5, 6'd7, 6'd31, 5'd2, 64'h8, 32'h9, 32'h9);
        #1;
        check("flush_is_ready", 64'(is_ready), 64'h0);
        step();
        flush = 1'b0; rs_valid = '0;
        check("flush_valid", 64'(ex_valid), 64'h0);
        check("flush_no_load", 64'(ex_dest), 64'h081);
        check("flush_stall_l0", 64'(stall_cnt[15:0]), 64'd2);
        check("flush_stall_l1", 64'(stall_cnt[31:16]), 64'd5);

        // stall counter saturation, then reset while stalled
        set_lane(0, 1'b1, 6'd5, 6'd7, 6'd40, 5'd1, 64'h9, 32'h1, 32'h2);
        step();
        rs_valid = '0;
        repeat (65540) step();
        check("stall_saturate", 64'(stall_cnt[15:0]), 64'hFFFF);
        check("stall_valid_held", 64'(ex_valid), 64'h1);
        reset = 1'b1;
        step();
        check("rst_stall_valid", 64'(ex_valid), 64'h0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
        check("rst_stall_dest", 64'(ex_dest), 64'h0);
        reset = 1'b0; ex_ready = 2'b11;
        step();
        check("rst_is_ready", 64'(is_ready), 64'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
